// File: rtl/joybus_tx.sv
// Joybus open-drain transmitter: sends 1-8 response bytes MSB first followed by a controller
// stop bit. JB_drive_low is a pull-low enable; the pad tristates the line when it is 0.
module joybus_tx #(
    parameter int unsigned CLKS_PER_US = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] data,
    input  logic [3:0]  num_bytes,
    output logic        busy,
    output logic        done,
    output logic        JB_drive_low
);

    localparam int unsigned CYC_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_US - 1);

    typedef enum logic [1:0] {StIdle, StBit, StStop} state_t;

    state_t           state;
    logic [63:0]      shreg;
    logic [6:0]       bits_left;
    logic [1:0]       qtr;
    logic [CYC_W-1:0] cyc;
    logic [3:0]       eff_bytes;

    always_comb begin
        eff_bytes = (num_bytes > 4'd8) ? 4'd8 : num_bytes;
    end

    // Counters describe the position of the cycle that follows each edge, so every output is
    // computed from the next position and registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            shreg        <= '0;
            bits_left    <= '0;
            qtr          <= '0;
            cyc          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            JB_drive_low <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    // done still high means this is the release cycle: start is ignored here
                    if (start && (eff_bytes != 4'd0) && !done) begin
                        shreg        <= data;
                        bits_left    <= {eff_bytes, 3'b000};
                        qtr          <= 2'd0;
                        cyc          <= '0;
                        busy         <= 1'b1;
                        JB_drive_low <= 1'b1;
                        state        <= StBit;
                    end
                end
                StBit: begin
                    if (cyc != CYC_LAST) begin
                        cyc <= cyc + 1'b1;
                    end else begin
                        cyc <= '0;
                        if (qtr != 2'd3) begin
                            qtr          <= qtr + 2'd1;
                            // Next quarter is 1 or 2 (low for a zero bit) unless it is 3
                            JB_drive_low <= (qtr != 2'd2) && !shreg[63];
                        end else begin
                            qtr          <= 2'd0;
                            JB_drive_low <= 1'b1;
                            if (bits_left == 7'd1) begin
                                bits_left <= '0;
                                state     <= StStop;
                            end else begin
                                shreg     <= {shreg[62:0], 1'b0};
                                bits_left <= bits_left - 7'd1;
                            end
                        end
                    end
                end
                StStop: begin
                    if (cyc != CYC_LAST) begin
                        cyc <= cyc + 1'b1;
                    end else begin
                        cyc <= '0;
                        if (qtr == 2'd0) begin
                            qtr <= 2'd1;
                        end else begin
                            qtr          <= 2'd0;
                            JB_drive_low <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            state        <= StIdle;
                        end
                    end
                end
                default: begin
                    state        <= StIdle;
                    busy         <= 1'b0;
                    JB_drive_low <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joybus_tx.sv
// Bench for joybus_tx: directed frames with a queue of expected frames; a line sampler decodes
// the waveform and checks each frame when done pulses.
module tb_joybus_tx;

    localparam int unsigned Q = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] data = '0;
    logic [3:0]  num_bytes = '0;
    logic        busy, done, JB_drive_low;

    joybus_tx #(.CLKS_PER_US(Q)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .data         (data),
        .num_bytes    (num_bytes),
        .busy         (busy),
        .done         (done),
        .JB_drive_low (JB_drive_low)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          nbits;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    int          cyc_n = 0;
    bit          in_frame = 0;
    bit          prev_drive = 0;
    int          first_low, low_start, last_low_start, last_width;
    int          nb, bad_width, bad_period, busy_cnt;
    logic [63:0] dec;

    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            in_frame   = 0;
            prev_drive = 0;
        end else begin
            if (JB_drive_low && !prev_drive) begin
                if (!in_frame) begin
                    in_frame   = 1;
                    first_low  = cyc_n;
                    nb         = 0;
                    dec        = '0;
                    bad_width  = 0;
                    bad_period = 0;
                    busy_cnt   = 0;
                    last_width = 0;
                end else if (cyc_n - last_low_start != 4 * Q) begin
                    bad_period++;
                end
                last_low_start = cyc_n;
                low_start      = cyc_n;
            end
            if (!JB_drive_low && prev_drive && in_frame) begin
                last_width = cyc_n - low_start;
                if (last_width == Q) begin
                    dec = {dec[62:0], 1'b1};
                    nb++;
                end else if (last_width == 3 * Q) begin
                    dec = {dec[62:0], 1'b0};
                    nb++;
                end else if (last_width != 2 * Q) begin
                    bad_width++;
                end
            end
            if (in_frame && busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    int   len;
                    e   = exp_q.pop_front();
                    len = cyc_n - first_low;
                    chk("bit_count", 64'(nb), 64'(e.nbits));
                    chk("bits", dec, e.data >> (64 - e.nbits));
                    chk("frame_len", 64'(len), 64'(e.nbits * 4 * Q + 2 * Q));
                    chk("stop_width", 64'(last_width), 64'(2 * Q));
                    chk("bad_low_widths", 64'(bad_width), 64'd0);
                    chk("bad_bit_periods", 64'(bad_period), 64'd0);
                    chk("busy_cycles", 64'(busy_cnt), 64'(len));
                end
                in_frame = 0;
            end
            prev_drive = JB_drive_low;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle; returns just after the accepting edge.
    task automatic send(input logic [63:0] d, input logic [3:0] n, input int nbits);
        data      = d;
        num_bytes = n;
        start     = 1'b1;
        if (nbits > 0) exp_q.push_back('{data: d, nbits: nbits});
        tick();
        start = 1'b0;
        if (nbits > 0) begin
            chk("accept_busy", 64'(busy), 64'd1);
            chk("accept_low", 64'(JB_drive_low), 64'd1);
        end
    endtask

    // Returns just after the edge that raised done.
    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (done) return;
        end
        chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        // 1: reset and idle
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_outputs", {61'd0, busy, done, JB_drive_low}, 64'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("idle_outputs", {61'd0, busy, done, JB_drive_low}, 64'd0);

        // 2: single byte A5
        send(64'hA500_0000_0000_0000, 4'd1, 8);
        wait_done();
        tick();

        // 3: full eight bytes
        send(64'h0123_4567_89AB_CDEF, 4'd8, 64);
        wait_done();
        tick();

        // 4: start mid-frame ignored, start in done cycle ignored, start right after accepted
        send(64'h3C00_0000_0000_0000, 4'd1, 8);
        for (int i = 0; i < 40; i++) tick();
        data      = 64'hFFFF_FFFF_FFFF_FFFF;
        num_bytes = 4'd8;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        data      = 64'hC35A_0000_0000_0000;
        num_bytes = 4'd2;
        start     = 1'b1;
        tick();
        chk("done_cycle_start_ignored", 64'(busy), 64'd0);
        exp_q.push_back('{data: 64'hC35A_0000_0000_0000, nbits: 16});
        tick();
        start = 1'b0;
        chk("post_done_accept_busy", 64'(busy), 64'd1);
        chk("post_done_accept_low", 64'(JB_drive_low), 64'd1);
        wait_done();
        tick();

        // 5: zero length ignored, 12 clamped to 8
        send(64'hDEAD_BEEF_0000_0000, 4'd0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("zero_len_idle", {61'd0, busy, done, JB_drive_low}, 64'd0);
            tick();
        end
        send(64'hFEDC_BA98_7654_3210, 4'd12, 64);
        wait_done();
        tick();

        // 6: reset during the low phase of bit 5
        send(64'hFF00_0000_0000_0000, 4'd1, 0);
        for (int i = 0; i < 81; i++) tick();
        chk("bit5_low_before_rst", 64'(JB_drive_low), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_frame", {61'd0, busy, done, JB_drive_low}, 64'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("after_abort_idle", {61'd0, busy, done, JB_drive_low}, 64'd0);
        send(64'h5A00_0000_0000_0000, 4'd1, 8);
        wait_done();
        for (int i = 0; i < 4; i++) tick();

        chk("frames_left", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
